pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 151 +++++++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: issues instruction fetches, registers the fetched word
// for decode, and handles redirects, including redirects while a fetch is unacked.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush,
  output logic        misalign_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic        flush_q, flush_d;
  logic        misalign_q, misalign_d;
  logic        cap_en;
  logic        redir_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      if_instr_q <= 32'h0;
      if_pc_q    <= 32'h0;
      if_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    flush_d    = 1'b0;
    misalign_d = misalign_q;
    imem_req   = 1'b0;
    cap_en     = !if_valid_q || !stall;
    redir_bad  = redirect_valid && (redirect_pc[1:0] != 2'b00);

    case (state_q)
      ST_BOOT: begin
        state_d = ST_REQ;
        if (redirect_valid) begin
          flush_d = 1'b1;
          if (redir_bad) begin
            state_d    = ST_ERR;
            misalign_d = 1'b1;
          end else begin
            pc_d = redirect_pc;
          end
        end
      end
      ST_REQ: begin
        // Once raised without ack, cap_en cannot drop: if_valid is either
        // already 0 or is being consumed, so the request stays stable.
        imem_req = cap_en;
        if (redirect_valid) begin
          flush_d    = 1'b1;
          if_valid_d = 1'b0;
          if (redir_bad) begin
            state_d    = ST_ERR;
            misalign_d = 1'b1;
          end else if (imem_req && !imem_ack) begin
            pend_pc_d = redirect_pc;
            state_d   = ST_DRAIN;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (imem_req && imem_ack) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
        end else if (!stall) begin
          if_valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Hold the stale request until memory takes it; its data is discarded.
        imem_req   = 1'b1;
        if_valid_d = 1'b0;
        if (redirect_valid) begin
          flush_d = 1'b1;
          if (redir_bad) begin
            state_d    = ST_ERR;
            misalign_d = 1'b1;
          end else if (imem_ack) begin
            pc_d    = redirect_pc;
            state_d = ST_REQ;
          end else begin
            pend_pc_d = redirect_pc;
          end
        end else if (imem_ack) begin
          pc_d    = pend_pc_q;
          state_d = ST_REQ;
        end
      end
      ST_ERR: begin
        if_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase
  end

  assign imem_addr    = pc_q;
  assign if_valid     = if_valid_q;
  assign if_instr     = if_instr_q;
  assign if_pc        = if_pc_q;
  assign flush        = flush_q;
  assign misalign_err = misalign_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, stall, redirects, drain, wrap and misalign.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] XORK   = 32'hDEAD_0000;
  localparam logic [1:0]  S_BOOT  = 2'd0;
  localparam logic [1:0]  S_REQ   = 2'd1;
  localparam logic [1:0]  S_DRAIN = 2'd2;
  localparam logic [1:0]  S_ERR   = 2'd3;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        misalign_err;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .flush         (flush),
    .misalign_err  (misalign_err),
    .state_dbg     (state_dbg)
  );

  // Memory returns a word derived from the address so dropped data is detectable.
  assign imem_rdata = imem_addr ^ XORK;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drive one cycle's inputs after the falling edge, then settle before checks.
  task automatic cyc(input logic s, input logic rv, input logic [31:0] rpc, input logic a);
    @(negedge clk);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ack       = a;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_state", state_dbg, S_BOOT);
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_valid", if_valid, 0);
    check_eq("rst_flush", flush, 0);
    check_eq("rst_err", misalign_err, 0);
    check_eq("rst_ifpc", if_pc, 0);
    check_eq("rst_addr", imem_addr, RST_PC);

    // Boot: cycle 1 idle, cycle 2 first request
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b1;
    #1;
    check_eq("boot_req0", imem_req, 0);
    check_eq("boot_state", state_dbg, S_BOOT);
    cyc(0, 0, 0, 1);
    check_eq("c2_req", imem_req, 1);
    check_eq("c2_addr", imem_addr, 32'h100);
    check_eq("c2_valid", if_valid, 0);
    cyc(0, 0, 0, 1);
    check_eq("c3_addr", imem_addr, 32'h104);
    check_eq("c3_ifpc", if_pc, 32'h100);
    check_eq("c3_instr", if_instr, 32'h100 ^ XORK);
    check_eq("c3_valid", if_valid, 1);

    // Stall for three cycles holding 0x104
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1);
      check_eq("stall_ifpc", if_pc, 32'h104);
      check_eq("stall_instr", if_instr, 32'h104 ^ XORK);
      check_eq("stall_valid", if_valid, 1);
      check_eq("stall_req", imem_req, 0);
      check_eq("stall_addr", imem_addr, 32'h108);
    end
    cyc(0, 0, 0, 1);
    check_eq("resume_req", imem_req, 1);
    check_eq("resume_addr", imem_addr, 32'h108);

    // Redirect to 0x200 while stalled with ack high
    cyc(1, 1, 32'h200, 1);
    check_eq("r1_ifpc", if_pc, 32'h108);
    cyc(0, 0, 0, 1);
    check_eq("r1_flush", flush, 1);
    check_eq("r1_valid", if_valid, 0);
    check_eq("r1_req", imem_req, 1);
    check_eq("r1_addr", imem_addr, 32'h200);
    cyc(0, 0, 0, 0);
    check_eq("r1_flush_end", flush, 0);
    check_eq("r1_ifpc2", if_pc, 32'h200);
    check_eq("r1_addr2", imem_addr, 32'h204);

    // Ack withheld at 0x204; redirect to 0x40 then to 0x80 while draining
    cyc(0, 1, 32'h40, 0);
    check_eq("d_valid", if_valid, 0);
    check_eq("d_req", imem_req, 1);
    cyc(0, 1, 32'h80, 0);
    check_eq("d_state", state_dbg, S_DRAIN);
    check_eq("d_hold_addr", imem_addr, 32'h204);
    check_eq("d_hold_req", imem_req, 1);
    check_eq("d_flush", flush, 1);
    cyc(0, 0, 0, 1);
    check_eq("d_state2", state_dbg, S_DRAIN);
    check_eq("d_flush2", flush, 1);
    check_eq("d_hold_addr2", imem_addr, 32'h204);
    cyc(0, 0, 0, 1);
    check_eq("d_exit_state", state_dbg, S_REQ);
    check_eq("d_dropped", if_valid, 0);
    check_eq("d_flush_end", flush, 0);
    check_eq("d_new_addr", imem_addr, 32'h80);
    cyc(0, 0, 0, 1);
    check_eq("d_ifpc", if_pc, 32'h80);
    check_eq("d_instr", if_instr, 32'h80 ^ XORK);
    check_eq("d_addr2", imem_addr, 32'h84);

    // Wrap at the top of the address space
    cyc(0, 1, 32'hFFFF_FFFC, 1);
    check_eq("w_addr_pre", imem_addr, 32'h88);
    cyc(0, 0, 0, 1);
    check_eq("w_addr_top", imem_addr, 32'hFFFF_FFFC);
    check_eq("w_valid_dropped", if_valid, 0);
    cyc(0, 0, 0, 1);
    check_eq("w_addr_wrap", imem_addr, 32'h0);
    check_eq("w_ifpc", if_pc, 32'hFFFF_FFFC);

    // Misaligned redirect is terminal
    cyc(0, 1, 32'h202, 1);
    check_eq("m_err_pre", misalign_err, 0);
    cyc(0, 1, 32'h100, 1);
    check_eq("m_state", state_dbg, S_ERR);
    check_eq("m_err", misalign_err, 1);
    check_eq("m_flush", flush, 1);
    check_eq("m_req", imem_req, 0);
    check_eq("m_valid", if_valid, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 1);
      check_eq("m_hold_state", state_dbg, S_ERR);
      check_eq("m_hold_err", misalign_err, 1);
      check_eq("m_hold_req", imem_req, 0);
      check_eq("m_hold_flush", flush, 0);
    end

    // Asynchronous reset mid-cycle returns to boot
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_state", state_dbg, S_BOOT);
    check_eq("ar_err", misalign_err, 0);
    check_eq("ar_addr", imem_addr, RST_PC);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("ar_boot_req", imem_req, 0);
    cyc(0, 0, 0, 1);
    check_eq("ar_req", imem_req, 1);
    check_eq("ar_req_addr", imem_addr, 32'h100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
